// File: rtl/tof_measure_ctrl.sv
// Time-of-flight measurement sequencer: fire, blank, listen for an echo, hold off
// until the repetition period ends; results are reported with a valid/ack handshake.
module tof_measure_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned BLANK   = 8,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned PERIOD  = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             trigger_in,
    output logic             tx_pulse,
    output logic             arm,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             timeout,
    output logic             overrun,
    output logic             result_valid,
    input  logic             result_ack
);

    localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] BlankLast   = CNT_W'(PULSE_W + BLANK - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] PeriodLast  = CNT_W'(PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFire,
        StBlank,
        StListen,
        StHoldoff
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap;
    logic [CNT_W-1:0] cap_val;
    logic             cap_to;

    logic [CNT_W-1:0] result_d;
    logic             timeout_d, overrun_d, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        cap     = 1'b0;
        cap_val = '0;
        cap_to  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start || continuous) state_d = StFire;
            end
            StFire: begin
                if (cnt_q == PulseLast) state_d = StBlank;
            end
            StBlank: begin
                if (cnt_q == BlankLast) state_d = StListen;
            end
            StListen: begin
                // An echo in the final listen cycle takes priority over the timeout.
                if (trigger_in) begin
                    cap     = 1'b1;
                    cap_val = cnt_q;
                    state_d = StHoldoff;
                end else if (cnt_q == TimeoutLast) begin
                    cap     = 1'b1;
                    cap_val = TimeoutVal;
                    cap_to  = 1'b1;
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if (cnt_q == PeriodLast) begin
                    cnt_d   = '0;
                    state_d = continuous ? StFire : StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        result_d  = result;
        timeout_d = timeout;
        overrun_d = overrun;
        valid_d   = result_valid;
        if (result_valid && result_ack) valid_d = 1'b0;
        if (cap) begin
            valid_d   = 1'b1;
            result_d  = cap_val;
            timeout_d = cap_to;
            overrun_d = result_valid && !result_ack;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tx_pulse     <= 1'b0;
            arm          <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_pulse     <= (state_d == StFire);
            arm          <= (state_d == StListen);
            busy         <= (state_d != StIdle);
            result       <= result_d;
            timeout      <= timeout_d;
            overrun      <= overrun_d;
            result_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_tof_measure_ctrl.sv
// Directed bench for tof_measure_ctrl; t is the cycle index since the first FIRE cycle,
// which equals cnt within a single measurement.
module tb_tof_measure_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, continuous, trigger_in, result_ack;
    logic             tx_pulse, arm, busy, timeout, overrun, result_valid;
    logic [CNT_W-1:0] result;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    tof_measure_ctrl #(
        .CNT_W  (CNT_W),
        .PULSE_W(4),
        .BLANK  (8),
        .TIMEOUT(100),
        .PERIOD (150)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .trigger_in  (trigger_in),
        .tx_pulse    (tx_pulse),
        .arm         (arm),
        .busy        (busy),
        .result      (result),
        .timeout     (timeout),
        .overrun     (overrun),
        .result_valid(result_valid),
        .result_ack  (result_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    task automatic to_t(input int k);
        if (k > t) step(k - t);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first FIRE cycle.
    task automatic fire();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
    endtask

    task automatic trig_at(input int k);
        to_t(k);
        trigger_in = 1'b1;
        step(1);
        trigger_in = 1'b0;
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        step(1);
        result_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; trigger_in = 1'b0; result_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        step(2);

        // Single shot, echo at 40
        fire();
        chk("t1_tx0", tx_pulse, 1);
        chk("t1_busy0", busy, 1);
        to_t(3);   chk("t1_tx3", tx_pulse, 1);
        to_t(4);   chk("t1_tx4", tx_pulse, 0);
        to_t(11);  chk("t1_arm11", arm, 0);
        to_t(12);  chk("t1_arm12", arm, 1);
        to_t(40);  chk("t1_arm40", arm, 1);
        trig_at(40);
        chk("t1_arm41", arm, 0);
        chk("t1_valid", result_valid, 1);
        chk("t1_result", result, 40);
        chk("t1_timeout", timeout, 0);
        chk("t1_overrun", overrun, 0);
        to_t(60);  chk("t1_valid_hold", result_valid, 1);
        to_t(149); chk("t1_busy149", busy, 1);
        to_t(150); chk("t1_busy150", busy, 0);
        do_ack();
        chk("t1_ack_valid", result_valid, 0);
        chk("t1_ack_result", result, 40);

        // Single shot, no echo
        fire();
        to_t(99);  chk("t2_arm99", arm, 1);
        chk("t2_valid99", result_valid, 0);
        to_t(100);
        chk("t2_arm100", arm, 0);
        chk("t2_valid", result_valid, 1);
        chk("t2_result", result, 100);
        chk("t2_timeout", timeout, 1);
        do_ack();
        chk("t2_ack", result_valid, 0);
        to_t(149); chk("t2_busy149", busy, 1);
        to_t(150); chk("t2_busy150", busy, 0);

        // Blanked echo, then echo at 30
        fire();
        trig_at(5);
        chk("t3_blank_valid", result_valid, 0);
        trig_at(30);
        chk("t3_result", result, 30);
        chk("t3_valid", result_valid, 1);
        do_ack();
        to_t(150);
        // Echo in last listen cycle, then one in HOLDOFF
        fire();
        trig_at(99);
        chk("t3b_result", result, 99);
        chk("t3b_timeout", timeout, 0);
        do_ack();
        chk("t3b_ack", result_valid, 0);
        trig_at(120);
        chk("t3b_hold_valid", result_valid, 0);
        chk("t3b_hold_result", result, 99);
        to_t(150);

        // Continuous mode with overrun and same-cycle ack
        continuous = 1'b1;
        @(negedge clk);
        t = 0;
        chk("t4_tx0", tx_pulse, 1);
        trig_at(40);
        chk("t4_r1", result, 40);
        chk("t4_ov1", overrun, 0);
        to_t(149); chk("t4_tx149", tx_pulse, 0);
        to_t(150); chk("t4_tx150", tx_pulse, 1);
        trig_at(205);
        chk("t4_r2", result, 55);
        chk("t4_ov2", overrun, 1);
        chk("t4_v2", result_valid, 1);
        to_t(300); chk("t4_tx300", tx_pulse, 1);
        to_t(306);
        continuous = 1'b0;
        to_t(340);
        trigger_in = 1'b1;
        result_ack = 1'b1;
        step(1);
        trigger_in = 1'b0;
        result_ack = 1'b0;
        chk("t4_v3", result_valid, 1);
        chk("t4_ov3", overrun, 0);
        chk("t4_r3", result, 40);
        do_ack();
        chk("t4_ack3", result_valid, 0);
        to_t(449); chk("t4_busy449", busy, 1);
        to_t(450); chk("t4_busy450", busy, 0);
        to_t(460); chk("t4_tx460", tx_pulse, 0);

        // start during LISTEN is ignored
        fire();
        to_t(20);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t5_tx21", tx_pulse, 0);
        to_t(110);
        chk("t5_result", result, 100);
        do_ack();
        to_t(150); chk("t5_busy150", busy, 0);
        to_t(152); chk("t5_tx152", tx_pulse, 0);

        // Reset in FIRE
        fire();
        to_t(2);
        chk("t6_tx2", tx_pulse, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_tx", tx_pulse, 0);
        chk("t6_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        // Reset in LISTEN
        fire();
        to_t(50);
        chk("t6_arm50", arm, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_arm", arm, 0);
        chk("t6_rst_busy2", busy, 0);
        chk("t6_rst_valid", result_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        step(2);
        chk("t6_idle_valid", result_valid, 0);
        fire();
        chk("t6_tx0", tx_pulse, 1);
        trig_at(40);
        chk("t6_result", result, 40);
        chk("t6_valid", result_valid, 1);
        chk("t6_timeout", timeout, 0);
        chk("t6_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tof_measure_ctrl.md
Name: tof_measure_ctrl

Overview:
- Sequences one rangefinder time-of-flight measurement: fires the transmit pulse, blanks the receiver, then listens for the echo trigger from the threshold-crossing trigger generator.
- Reports the elapsed cycle count with a valid/ack handshake.
- Supports single-shot and free-running modes, with a fixed repetition period.
- Sits between the control/host interface and the analog front-end echo detection path.

Parameters:
- CNT_W, 16, width of the time-of-flight/period counter and the result.
- PULSE_W, 4, transmit pulse length in clk cycles (≥1).
- BLANK, 8, cycles after the end of the transmit pulse during which echo triggers are ignored (≥1).
- TIMEOUT, 1000, last counter value at which an echo is still accepted plus one. Constraint: TIMEOUT > PULSE_W+BLANK.
- PERIOD, 2000, cycles from one transmit pulse start to the next in continuous mode. Constraint: PERIOD > TIMEOUT, PERIOD < 2^CNT_W.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-shot request; sampled only in IDLE.
- continuous, in, 1, free-running mode enable; sampled in IDLE and at the end of HOLDOFF.
- trigger_in, in, 1, echo trigger pulse from the trigger generator (one-cycle pulse).
- tx_pulse, out, 1, transmit excitation drive.
- arm, out, 1, high while echoes are being accepted (LISTEN state).
- busy, out, 1, high in any state other than IDLE.
- result, out, CNT_W, captured time of flight in clk cycles, measured from the first tx_pulse cycle.
- timeout, out, 1, qualifies result: 1 = no echo received.
- overrun, out, 1, qualifies result: 1 = the previous result was overwritten before ack.
- result_valid, out, 1, result pending.
- result_ack, in, 1, consumer acknowledge.

Behaviour:
- Reset (async, immediate): state=IDLE; tx_pulse, arm, busy, result_valid, timeout, overrun = 0; result = 0; counter = 0.
- All outputs are registered.
- States: IDLE, FIRE, BLANK, LISTEN, HOLDOFF.
- IDLE:
  - If start or continuous is sampled high → FIRE on the next edge, with cnt=0 in the first FIRE cycle.
  - start pulses in any state other than IDLE are ignored.
- cnt:
  - Increments by 1 every cycle in FIRE, BLANK, LISTEN and HOLDOFF.
  - Never wraps, because PERIOD < 2^CNT_W.
- FIRE:
  - tx_pulse=1 for exactly PULSE_W cycles (cnt 0..PULSE_W-1).
  - Then → BLANK.
- BLANK:
  - Lasts BLANK cycles; trigger_in is ignored.
  - Then → LISTEN, entered at cnt = PULSE_W+BLANK.
- LISTEN:
  - arm=1.
  - trigger_in=1 → capture result=cnt of that cycle, timeout=0 → HOLDOFF.
  - Else, if cnt == TIMEOUT-1 → result=TIMEOUT, timeout=1 → HOLDOFF.
  - A trigger in the cnt==TIMEOUT-1 cycle wins: result=TIMEOUT-1, timeout=0.
- Capture:
  - Sets result_valid=1 on the following edge, together with result and timeout.
  - overrun = result_valid at the moment of capture (and not acked in that same cycle).
- Handshake:
  - result_valid holds until result_ack is sampled high while valid=1; then it clears next edge. result, timeout and overrun keep their values.
  - result_ack while valid=0 has no effect.
  - A capture in the same cycle as an ack sets valid=1 with overrun=0.
- HOLDOFF:
  - Triggers are ignored.
  - When cnt == PERIOD-1: if continuous=1 → FIRE with cnt=0; else → IDLE.
  - Dropping continuous mid-measurement completes the current measurement, then returns to IDLE.
- Reset mid-operation aborts immediately: tx_pulse drops asynchronously and no result is reported.

Test Plan (PULSE_W=4, BLANK=8, TIMEOUT=100, PERIOD=150, CNT_W=16):
- Single start, trigger_in pulse at cnt=40 → tx_pulse high for cnt 0..3; arm high from cnt 12 to 40; result=40, timeout=0, result_valid=1 until ack; busy drops 150 cycles after FIRE entry.
- Single start, no trigger → result=100, timeout=1, valid=1; arm falls after cnt 99; return to IDLE after cnt 149.
- Triggers at cnt=5 (blanked) and cnt=30 → result=30. Trigger at cnt=99 → result=99, timeout=0. Trigger at cnt=120 (HOLDOFF) → ignored.
- continuous=1, echoes at 40 then 55, no ack → tx_pulse starts every 150 cycles; second result=55 with overrun=1; ack clears valid; a third result with an ack in the same cycle as capture → overrun=0.
- start asserted during LISTEN → ignored, with no extra tx_pulse. Dropping continuous during BLANK → current result still reported, then IDLE.
- rst asserted during FIRE (cnt=2) and during LISTEN (cnt=50) → tx_pulse/arm/busy go 0 immediately, no result_valid; a subsequent start gives a normal measurement.
